// File: rtl/switch_pkg.sv
// switch_pkg: definitions shared by every block of the 4-port switch.
//   NPORTS_DFLT / DATA_W_DFLT : default port count and payload width
//   pkt_type_e                : ingress packet class
//   pkt_t                     : packet layout {source, target, data} at default widths
//   popcount / classify       : derive the packet class from a target bitmap
package switch_pkg;

  localparam int NPORTS_DFLT = 4;
  localparam int DATA_W_DFLT = 8;

  typedef enum logic [1:0] {
    UNICAST   = 2'd0,
    MULTICAST = 2'd1,
    BROADCAST = 2'd2,
    INVALID   = 2'd3
  } pkt_type_e;

  typedef struct packed {
    logic [NPORTS_DFLT-1:0] source;
    logic [NPORTS_DFLT-1:0] target;
    logic [DATA_W_DFLT-1:0] data;
  } pkt_t;

  // Counts the set bits of a target bitmap. The bitmap is zero-extended
  // to 32 bits by the caller so that one function serves any port count.
  function automatic int unsigned popcount(input logic [31:0] vec);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      ones += 32'(vec[i]);
    end
    return ones;
  endfunction

  // A packet that targets every port is broadcast, so the classifier needs
  // to know how many ports the switch has.
  function automatic pkt_type_e classify(input logic [31:0] target,
                                         input int unsigned nports);
    int unsigned ones;
    ones = popcount(target);
    if (ones == 0) begin
      return INVALID;
    end else if (ones == 1) begin
      return UNICAST;
    end else if (ones == nports) begin
      return BROADCAST;
    end else begin
      return MULTICAST;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and read-side head.
//   clk      : clock, rising edge
//   rst_n    : synchronous reset, active high
//   push_i   : write wdata_i (ignored when full unless a pop happens too)
//   pop_i    : drop the head entry (ignored when empty)
//   wdata_i  : entry to write
//   rdata_o  : current head entry (valid while empty_o = 0)
//   full_o   : DEPTH entries stored
//   empty_o  : no entries stored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  // A push into a full FIFO is legal when the head leaves in the same
  // cycle: the freed slot is the one the write pointer already points at.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // The head is read straight from storage; the entry under rdPtr_q is
  // never overwritten while it is still the head, so it holds steady.
  assign rdata_o = mem_q[rdPtr_q];

  // Storage, pointers and occupancy. Storage is cleared on reset so the
  // head fields read as zero when nothing has been written yet. DEPTH is a
  // power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= wdata_i;
        wrPtr_q        <= wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/port_if.sv
// port_if: adapter between one external switch port and the switch core.
//   Ingress: valid_in/source_in/target_in/data_in are validated, classified
//   and queued; the queue head is offered to the core on core_valid/
//   core_source/core_target/core_data/core_type and leaves on core_ready.
//   Rejected packets raise err for one cycle and bump drop_cnt (saturating).
//   Egress: egr_valid/egr_source/egr_target/egr_data from the core are
//   registered onto valid_out/source_out/target_out/data_out.
//   clk is the only clock; rst_n is a synchronous, active-high reset.
module port_if
  import switch_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int NPORTS     = NPORTS_DFLT,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [NPORTS-1:0] source_in,
  input  logic [NPORTS-1:0] target_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              core_valid,
  input  logic              core_ready,
  output logic [NPORTS-1:0] core_source,
  output logic [NPORTS-1:0] core_target,
  output logic [DATA_W-1:0] core_data,
  output logic [1:0]        core_type,
  input  logic              egr_valid,
  input  logic [NPORTS-1:0] egr_source,
  input  logic [NPORTS-1:0] egr_target,
  input  logic [DATA_W-1:0] egr_data,
  output logic              valid_out,
  output logic [NPORTS-1:0] source_out,
  output logic [NPORTS-1:0] target_out,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        drop_cnt,
  output logic              err
);

  localparam logic [NPORTS-1:0] SRC_ONEHOT = NPORTS'(1) << PORT_ID;
  localparam int ENTRY_W = 2 + 2 * NPORTS + DATA_W;

  pkt_type_e          ingType;
  logic               srcOk;
  logic               pushReq;
  logic               popReq;
  logic               dropReq;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [ENTRY_W-1:0] fifoWdata;
  logic [ENTRY_W-1:0] fifoRdata;

  logic [7:0]         dropCnt_q;
  logic [7:0]         dropCnt_d;
  logic               err_q;

  logic               validOut_q;
  logic [NPORTS-1:0]  sourceOut_q;
  logic [NPORTS-1:0]  targetOut_q;
  logic [DATA_W-1:0]  dataOut_q;

  // Ingress validation. A packet must come from this port's own one-hot
  // source and name at least one target. It is queued when there is room,
  // where "room" includes the slot the core frees by popping this cycle.
  always_comb begin
    ingType = classify(32'(target_in), NPORTS);
    srcOk   = (source_in == SRC_ONEHOT);
    popReq  = core_ready & ~fifoEmpty;
    pushReq = valid_in & srcOk & (ingType != INVALID) & (~fifoFull | popReq);
    dropReq = valid_in & ~pushReq;
  end

  // The class travels with the packet so the core sees it alongside the head.
  assign fifoWdata = {ingType, source_in, target_in, data_in};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pushReq),
    .pop_i   (popReq),
    .wdata_i (fifoWdata),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign core_valid  = ~fifoEmpty;
  assign core_type   = fifoRdata[ENTRY_W-1 -: 2];
  assign core_source = fifoRdata[2*NPORTS+DATA_W-1 -: NPORTS];
  assign core_target = fifoRdata[NPORTS+DATA_W-1 -: NPORTS];
  assign core_data   = fifoRdata[DATA_W-1:0];

  // Drop counter sticks at 255 rather than wrapping.
  always_comb begin
    dropCnt_d = dropCnt_q;
    if (dropReq && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end
  end

  // Drop bookkeeping: err mirrors the drop decision one cycle later.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      dropCnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      dropCnt_q <= dropCnt_d;
      err_q     <= dropReq;
    end
  end

  assign drop_cnt = dropCnt_q;
  assign err      = err_q;

  // Egress register. The strobe is a plain one-cycle delay; the fields only
  // load on a delivered packet so they keep the last packet once idle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      validOut_q  <= 1'b0;
      sourceOut_q <= '0;
      targetOut_q <= '0;
      dataOut_q   <= '0;
    end else begin
      validOut_q <= egr_valid;
      if (egr_valid) begin
        sourceOut_q <= egr_source;
        targetOut_q <= egr_target;
        dataOut_q   <= egr_data;
      end
    end
  end

  assign valid_out  = validOut_q;
  assign source_out = sourceOut_q;
  assign target_out = targetOut_q;
  assign data_out   = dataOut_q;

endmodule

// File: tb/tb_port_if.sv
// tb_port_if: directed bench for port_if (PORT_ID 0, 4 ports, 8-bit data).
// Packets the bench expects to be queued go into a scoreboard queue when
// they are driven; the queue head is compared with the DUT head every cycle
// it should be present and is retired when the core pops it.
module tb_port_if;
  import switch_pkg::*;

  localparam int         PORT_ID = 0;
  localparam int         DEPTH   = 4;
  localparam logic [3:0] ONEHOT  = 4'b0001;

  typedef struct {
    pkt_t       pkt;
    logic [1:0] typ;
  } sbEntry_t;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [3:0] source_in;
  logic [3:0] target_in;
  logic [7:0] data_in;
  logic       core_valid;
  logic       core_ready;
  logic [3:0] core_source;
  logic [3:0] core_target;
  logic [7:0] core_data;
  logic [1:0] core_type;
  logic       egr_valid;
  logic [3:0] egr_source;
  logic [3:0] egr_target;
  logic [7:0] egr_data;
  logic       valid_out;
  logic [3:0] source_out;
  logic [3:0] target_out;
  logic [7:0] data_out;
  logic [7:0] drop_cnt;
  logic       err;

  int         checks;
  int         errors;

  sbEntry_t   expQ[$];
  logic [7:0] expDrop;
  logic       expErr;
  logic       expValidOut;
  logic [3:0] expSrcOut;
  logic [3:0] expTgtOut;
  logic [7:0] expDataOut;

  port_if #(
    .PORT_ID    (PORT_ID),
    .NPORTS     (4),
    .DATA_W     (8),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .source_in   (source_in),
    .target_in   (target_in),
    .data_in     (data_in),
    .core_valid  (core_valid),
    .core_ready  (core_ready),
    .core_source (core_source),
    .core_target (core_target),
    .core_data   (core_data),
    .core_type   (core_type),
    .egr_valid   (egr_valid),
    .egr_source  (egr_source),
    .egr_target  (egr_target),
    .egr_data    (egr_data),
    .valid_out   (valid_out),
    .source_out  (source_out),
    .target_out  (target_out),
    .data_out    (data_out),
    .drop_cnt    (drop_cnt),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a broken DUT or bench can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Independent class model: number of targets decides the class.
  function automatic logic [1:0] expType(input logic [3:0] tgt);
    case ($countones(tgt))
      0:       return 2'd3;
      1:       return 2'd0;
      4:       return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every registered output against the model after an edge.
  task automatic checkAfterEdge();
    checkOutput("coreValid", 32'(core_valid), 32'(expQ.size() > 0));
    checkOutput("err",       32'(err),        32'(expErr));
    checkOutput("dropCnt",   32'(drop_cnt),   32'(expDrop));
    checkOutput("validOut",  32'(valid_out),  32'(expValidOut));
    checkOutput("sourceOut", 32'(source_out), 32'(expSrcOut));
    checkOutput("targetOut", 32'(target_out), 32'(expTgtOut));
    checkOutput("dataOut",   32'(data_out),   32'(expDataOut));
  endtask

  // One clock cycle: compare the head, drive inputs at the falling edge,
  // update the model, then check outputs just after the rising edge.
  task automatic applyStimulus(input logic v, input logic [3:0] src,
                               input logic [3:0] tgt, input logic [7:0] d,
                               input logic rdy, input logic ev,
                               input logic [3:0] es, input logic [3:0] et,
                               input logic [7:0] ed);
    bit popping;
    bit accept;
    sbEntry_t ent;
    @(negedge clk);
    if (expQ.size() > 0) begin
      checkOutput("coreSource", 32'(core_source), 32'(expQ[0].pkt.source));
      checkOutput("coreTarget", 32'(core_target), 32'(expQ[0].pkt.target));
      checkOutput("coreData",   32'(core_data),   32'(expQ[0].pkt.data));
      checkOutput("coreType",   32'(core_type),   32'(expQ[0].typ));
    end
    rst_n      = 1'b0;
    valid_in   = v;
    source_in  = src;
    target_in  = tgt;
    data_in    = d;
    core_ready = rdy;
    egr_valid  = ev;
    egr_source = es;
    egr_target = et;
    egr_data   = ed;
    popping = rdy && (expQ.size() > 0);
    accept  = v && (src == ONEHOT) && (tgt != 4'b0000) &&
              ((expQ.size() < DEPTH) || popping);
    if (popping) void'(expQ.pop_front());
    if (accept) begin
      ent.pkt.source = src;
      ent.pkt.target = tgt;
      ent.pkt.data   = d;
      ent.typ        = expType(tgt);
      expQ.push_back(ent);
    end
    expErr = v && !accept;
    if (expErr && (expDrop != 8'hFF)) expDrop = expDrop + 8'd1;
    expValidOut = ev;
    if (ev) begin
      expSrcOut  = es;
      expTgtOut  = et;
      expDataOut = ed;
    end
    @(posedge clk);
    #1;
    checkAfterEdge();
  endtask

  // Holds reset for n edges while an ingress packet and an egress packet
  // are in flight; neither may survive nor be counted.
  task automatic applyReset(input int n, input logic [3:0] src);
    @(negedge clk);
    rst_n      = 1'b1;
    valid_in   = 1'b1;
    source_in  = src;
    target_in  = 4'b0001;
    data_in    = 8'hEE;
    core_ready = 1'b0;
    egr_valid  = 1'b1;
    egr_source = 4'b0010;
    egr_target = 4'b0001;
    egr_data   = 8'hDD;
    expQ.delete();
    expDrop     = 8'd0;
    expErr      = 1'b0;
    expValidOut = 1'b0;
    expSrcOut   = 4'b0;
    expTgtOut   = 4'b0;
    expDataOut  = 8'h00;
    repeat (n) @(posedge clk);
    #1;
    checkAfterEdge();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b1;
    valid_in   = 1'b0;
    source_in  = '0;
    target_in  = '0;
    data_in    = '0;
    core_ready = 1'b0;
    egr_valid  = 1'b0;
    egr_source = '0;
    egr_target = '0;
    egr_data   = '0;

    applyReset(3, ONEHOT);

    // Unicast in, then the same packet delivered back on egress.
    applyStimulus(1, 4'b0001, 4'b0001, 8'hAA, 1, 0, 4'h0, 4'h0, 8'h00);
    applyStimulus(0, 4'b0000, 4'b0000, 8'h00, 1, 1, 4'b0001, 4'b0001, 8'hAA);
    applyStimulus(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'h0, 4'h0, 8'h00);

    // Multicast, broadcast, then a zero target that must be dropped.
    applyStimulus(1, 4'b0001, 4'b0011, 8'h11, 1, 0, 4'h0, 4'h0, 8'h00);
    applyStimulus(1, 4'b0001, 4'b1111, 8'h22, 1, 0, 4'h0, 4'h0, 8'h00);
    applyStimulus(1, 4'b0001, 4'b0000, 8'h33, 1, 0, 4'h0, 4'h0, 8'h00);
    applyStimulus(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'h0, 4'h0, 8'h00);

    // Wrong source port.
    applyStimulus(1, 4'b0100, 4'b0010, 8'h55, 1, 0, 4'h0, 4'h0, 8'h00);
    applyStimulus(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'h0, 4'h0, 8'h00);

    // Fill with the core stalled; the fifth packet overflows.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 4'b0001, 4'b0010, 8'(i), 0, 0, 4'h0, 4'h0, 8'h00);
    end
    // Push into a full FIFO while the head leaves, with an egress packet too.
    applyStimulus(1, 4'b0001, 4'b1000, 8'h06, 1, 1, 4'b0100, 4'b0001, 8'hCC);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'h0, 4'h0, 8'h00);
    end

    // Reset with three packets queued and a bad packet in flight.
    applyReset(1, ONEHOT);
    for (int i = 7; i <= 9; i++) begin
      applyStimulus(1, 4'b0001, 4'b0100, 8'(i), 0, 0, 4'h0, 4'h0, 8'h00);
    end
    applyReset(1, 4'b1000);
    applyStimulus(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'h0, 4'h0, 8'h00);

    // Drive the drop counter past its ceiling.
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1, 4'b0010, 4'b0001, 8'(i), 1, 0, 4'h0, 4'h0, 8'h00);
    end
    applyStimulus(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'h0, 4'h0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/port_if.md
Name: port_if

Overview:
- Per-port adapter between one external switch port and the 4-port switch core.
- Ingress: accepts packets from the port pins, validates them, classifies them and buffers them in a small FIFO toward the core.
- Egress: registers packets leaving the core onto the port output pins.
- One instance per port, PORT_ID 0..3; the verification agent drives the *_in pins and monitors the *_out pins.

Parameters:
- PORT_ID, 0, index of this port (0..NPORTS-1); defines the legal one-hot source value.
- NPORTS, 4, number of switch ports; width of source/target fields.
- DATA_W, 8, payload width.
- FIFO_DEPTH, 4, ingress FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-high (asserted = 1, despite the legacy name).
- valid_in  in  1  ingress packet strobe, one packet per cycle.
- source_in  in  NPORTS  one-hot source port.
- target_in  in  NPORTS  target port bitmap.
- data_in  in  DATA_W  payload.
- core_valid  out  1  ingress FIFO non-empty.
- core_ready  in  1  core pops the FIFO head when core_valid & core_ready.
- core_source  out  NPORTS  head packet source.
- core_target  out  NPORTS  head packet target.
- core_data  out  DATA_W  head packet payload.
- core_type  out  2  head packet class.
- egr_valid  in  1  core delivers a packet to this port.
- egr_source  in  NPORTS  delivered packet source.
- egr_target  in  NPORTS  delivered packet target.
- egr_data  in  DATA_W  delivered packet payload.
- valid_out  out  1  egress strobe to the port pins.
- source_out  out  NPORTS  egress source.
- target_out  out  NPORTS  egress target.
- data_out  out  DATA_W  egress payload.
- drop_cnt  out  8  count of dropped ingress packets, saturating at 255.
- err  out  1  one-cycle pulse when an ingress packet is dropped.

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - FIFO emptied; core_valid=0.
  - valid_out=0; source_out, target_out and data_out = 0.
  - drop_cnt=0; err=0.
  - Reset has priority over every other event. Packets in flight are discarded, not counted.
- Ingress classification, computed from target_in popcount:
  - 1 → type 0 (unicast)
  - 2 or 3 → type 1 (multicast)
  - 4 (all ones) → type 2 (broadcast)
  - 0 → type 3 (invalid)
- Self-targeting (target bit PORT_ID set) is legal.
- Ingress acceptance: a packet with valid_in=1 is written to the FIFO only if all hold:
  - source_in == 1<<PORT_ID
  - target_in != 0
  - the FIFO is not full, or a pop occurs in the same cycle
- Otherwise the packet is dropped: err pulses high the next cycle and drop_cnt increments, saturating at 255.
- FIFO:
  - Latency 1: a packet written at edge N appears at the head at edge N. core_valid is high in the cycle after the write.
  - Head fields (core_source, core_target, core_data, core_type) are registered. They hold stable while core_valid=1 and core_ready=0.
  - Pop on an empty FIFO is ignored.
  - Simultaneous push+pop when full: both occur, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
- Egress:
  - valid_out is egr_valid delayed 1 cycle.
  - Fields are captured only when egr_valid=1. valid_out deasserts the cycle after egr_valid drops; fields then hold their last value.
  - No backpressure on egress.
- No combinational path from any input to any output.

Decomposition:
- Shared package switch_pkg:
  - NPORTS and DATA_W defaults
  - pkt_type_e enum {UNICAST=0, MULTICAST=1, BROADCAST=2, INVALID=3}
  - popcount-based classify function
  - packet struct {source, target, data}
- One sub-module: sync_fifo (parameterised width/depth, full/empty, push/pop).
- Classification and egress register stay in port_if.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles → all outputs 0, core_valid=0, drop_cnt=0.
- PORT_ID=0, send source=4'b0001, target=4'b0001, data=8'hAA; core_ready=1 → one cycle later core_valid=1, core_data=AA, core_type=0. Drive egr_valid with the same packet → next cycle valid_out=1, data_out=AA, target_out=0001.
- Targets 4'b0011, 4'b1111, 4'b0000 → core_type 1, then 2; the zero target is dropped with err pulse and drop_cnt=1.
- Wrong source (4'b0100 on PORT_ID=0), data 8'h55 → dropped, drop_cnt increments, core_valid stays 0.
- core_ready=0, send 5 valid packets with data 1..5 → first 4 queued, 5th dropped. Then core_ready=1 pops data 1,2,3,4 in order. Also cover push while full with simultaneous pop: accepted.
- Assert reset while the FIFO holds 3 packets → next cycle core_valid=0 and drop_cnt unchanged from 0.
